// File: rtl/bpred_pkg.sv
// -----------------------------------------------------------------------------
// bpred_pkg -- shared definitions for the fetch-stage branch predictor / BTB.
//
// Contents:
//   clog2        constant function used to size the BTB index
//   CTR_SNT/WT/ST  saturating-counter encodings at the default counter width
//   ctr_max/ctr_wt width-generic forms of the all-ones / weakly-taken encodings
//   sat_inc/sat_dec  saturating next-state helpers for a counter of width w
//   btb_entry_t  entry layout at the default configuration (64/10/2)
//
// Counter helpers work on a CTR_MAX_W-bit container so one function serves
// every counter width up to CTR_MAX_W; callers cast in and out at their width.
// -----------------------------------------------------------------------------
package bpred_pkg;

  localparam int CTR_MAX_W  = 8;
  localparam int DEF_ADDR_W = 64;
  localparam int DEF_TAG_W  = 10;
  localparam int DEF_CTR_W  = 2;

  localparam logic [DEF_CTR_W-1:0] CTR_SNT = 2'b00;  // strongly not taken
  localparam logic [DEF_CTR_W-1:0] CTR_WT  = 2'b10;  // weakly taken
  localparam logic [DEF_CTR_W-1:0] CTR_ST  = 2'b11;  // strongly taken

  typedef struct packed {
    logic                  valid;
    logic [DEF_TAG_W-1:0]  tag;
    logic                  is_cond;
    logic [DEF_CTR_W-1:0]  ctr;
    logic [DEF_ADDR_W-1:0] target;
  } btb_entry_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // All-ones value of a w-bit counter.
  function automatic logic [CTR_MAX_W-1:0] ctr_max(input int w);
    return CTR_MAX_W'((33'd1 << w) - 33'd1);
  endfunction

  // Weakly-taken value of a w-bit counter: MSB set, all other bits clear.
  function automatic logic [CTR_MAX_W-1:0] ctr_wt(input int w);
    return CTR_MAX_W'(33'd1 << (w - 1));
  endfunction

  function automatic logic [CTR_MAX_W-1:0] sat_inc(input logic [CTR_MAX_W-1:0] cur,
                                                   input int w);
    logic [CTR_MAX_W-1:0] mx;
    mx = ctr_max(w);
    return (cur >= mx) ? mx : cur + CTR_MAX_W'(1);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] sat_dec(input logic [CTR_MAX_W-1:0] cur,
                                                   input int w);
    return (cur == '0) ? '0 : cur - CTR_MAX_W'(1);
  endfunction

endpackage

// File: rtl/bpred_sat_ctr.sv
// -----------------------------------------------------------------------------
// bpred_sat_ctr -- combinational next state of one CTR_W-bit saturating counter.
//
// Ports:
//   cur    in  CTR_W  current counter value
//   taken  in  1      1 = count up, 0 = count down
//   en     in  1      0 = hold cur
//   nxt    out CTR_W  next counter value (never wraps)
// -----------------------------------------------------------------------------
module bpred_sat_ctr
  import bpred_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] cur,
  input  logic             taken,
  input  logic             en,
  output logic [CTR_W-1:0] nxt
);

  // NOTE: every variable written in always_comb gets a default first so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    nxt = cur;
    if (en) begin
      if (taken) nxt = CTR_W'(sat_inc(CTR_MAX_W'(cur), CTR_W));
      else       nxt = CTR_W'(sat_dec(CTR_MAX_W'(cur), CTR_W));
    end
  end

endmodule

// File: rtl/bpred_btb.sv
// -----------------------------------------------------------------------------
// bpred_btb -- direct-mapped branch predictor + branch target buffer.
//
// Lookup (combinational, zero latency from registered state):
//   lk_pc in, lk_hit / lk_taken / lk_target out (taken/target are 0 on a miss)
// Update (applied at the rising edge when upd_valid=1):
//   upd_valid, upd_pc, upd_is_cond, upd_taken, upd_target in
// Status:
//   occupancy out  number of valid entries
// Clock/reset: clk rising edge, rst synchronous active-high.
//
// idx = pc[IDX_W+1:2], tag = pc[IDX_W+TAG_W+1:IDX_W+2]; pc[1:0] is ignored.
//
// Build option: define BPRED_BYPASS_EN to forward a same-cycle update to a
// lookup of the same index; undefined, the lookup sees the pre-update entry.
// -----------------------------------------------------------------------------
module bpred_btb
  import bpred_pkg::*;
#(
  parameter  int ADDR_W  = 64,
  parameter  int ENTRIES = 16,
  parameter  int TAG_W   = 10,
  parameter  int CTR_W   = 2,
  localparam int IDX_W   = clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              lk_hit,
  output logic              lk_taken,
  output logic [ADDR_W-1:0] lk_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_is_cond,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  output logic [IDX_W:0]    occupancy
);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic              is_cond;
    logic [CTR_W-1:0]  ctr;
    logic [ADDR_W-1:0] target;
  } entry_t;

  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_wt(CTR_W));

  entry_t             mem [ENTRIES];
  logic [ENTRIES-1:0] valid_q;
  logic [IDX_W:0]     occ_q;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Offset bits and any PC bits above the tag take no part in the lookup.
  logic unused_pc;
  assign unused_pc = ^{lk_pc, upd_pc};

  // ---------------------------------------------------------------- update --
  entry_t           upd_cur, upd_new;
  logic             upd_hit, wr_en, alloc_new;
  logic [CTR_W-1:0] ctr_nxt;

  assign upd_cur = mem[upd_idx];
  assign upd_hit = valid_q[upd_idx] && (upd_cur.tag == upd_tag);

  bpred_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
    .cur   (upd_cur.ctr),
    .taken (upd_taken),
    .en    (upd_hit && upd_cur.is_cond),
    .nxt   (ctr_nxt)
  );

  // Everything is gated by upd_valid so undriven upd_* fields never reach
  // state, and by rst so an update in the reset cycle is dropped.
  always_comb begin
    upd_new   = upd_cur;
    wr_en     = 1'b0;
    alloc_new = 1'b0;
    if (upd_valid && !rst) begin
      if (upd_hit) begin
        wr_en           = 1'b1;
        upd_new.is_cond = upd_is_cond;
        if (upd_cur.is_cond) begin
          upd_new.ctr = ctr_nxt;
          if (upd_taken) upd_new.target = upd_target;
        end else begin
          upd_new.target = upd_target;  // counter kept as-is for B/BL
        end
      end else if (upd_taken) begin
        wr_en           = 1'b1;
        alloc_new       = !valid_q[upd_idx];  // replacement does not count
        upd_new.tag     = upd_tag;
        upd_new.is_cond = upd_is_cond;
        upd_new.ctr     = CTR_INIT;
        upd_new.target  = upd_target;
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      occ_q   <= '0;
    end else if (wr_en) begin
      valid_q[upd_idx] <= 1'b1;
      if (alloc_new) occ_q <= occ_q + (IDX_W+1)'(1);
    end
  end

  // NOTE: entry storage has no reset; the valid bits alone make stale
  // contents invisible, so the array can map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (wr_en) mem[upd_idx] <= upd_new;
  end

  // ---------------------------------------------------------------- lookup --
  logic              lk_valid, lk_cond, lk_ctr_msb;
  logic [TAG_W-1:0]  lk_etag;
  logic [ADDR_W-1:0] lk_etgt;

  always_comb begin
    lk_valid   = valid_q[lk_idx];
    lk_etag    = mem[lk_idx].tag;
    lk_cond    = mem[lk_idx].is_cond;
    lk_ctr_msb = mem[lk_idx].ctr[CTR_W-1];
    lk_etgt    = mem[lk_idx].target;
`ifdef BPRED_BYPASS_EN
    if (wr_en && (upd_idx == lk_idx)) begin
      lk_valid   = 1'b1;
      lk_etag    = upd_new.tag;
      lk_cond    = upd_new.is_cond;
      lk_ctr_msb = upd_new.ctr[CTR_W-1];
      lk_etgt    = upd_new.target;
    end
`else
    // No forwarding: a same-cycle update to this index is seen next cycle.
`endif
  end

  assign lk_hit    = lk_valid && (lk_etag == lk_tag);
  assign lk_taken  = lk_hit && (!lk_cond || lk_ctr_msb);
  assign lk_target = lk_hit ? lk_etgt : '0;
  assign occupancy = occ_q;

endmodule

// File: doc/bpred_btb.md
Name: bpred_btb

Overview:
- Parametrised branch predictor and branch target buffer (BTB) for the fetch stage of the pipelined 64-bit CPU.
- Replaces the fixed "delay and re-fetch" branch handling with a single-cycle prediction of taken/not-taken and target, looked up from the current PC.
- Exec stage reports the resolved outcome through an update port; the predictor learns with saturating counters.
- Direct-mapped; depth, tag width, address width and counter width are generalised.

Parameters:
- ADDR_W, 64, PC and target width in bits.
- ENTRIES, 16, number of BTB entries; power of 2, minimum 2; IDX_W = log2(ENTRIES).
- TAG_W, 10, tag bits stored per entry; ADDR_W >= IDX_W+TAG_W+2.
- CTR_W, 2, saturating-counter width; minimum 1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- lk_pc  in  ADDR_W  fetch PC to look up
- lk_hit  out  1  valid entry with matching tag
- lk_taken  out  1  predicted taken
- lk_target  out  ADDR_W  predicted target; 0 when lk_hit=0
- upd_valid  in  1  resolved branch this cycle
- upd_pc  in  ADDR_W  PC of the resolved branch
- upd_is_cond  in  1  1 = B.cond/CBZ, 0 = B/BL
- upd_taken  in  1  resolved direction
- upd_target  in  ADDR_W  resolved target
- occupancy  out  IDX_W+1  number of valid entries

Behaviour:
- Addressing:
  - idx = pc[IDX_W+1:2].
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2].
  - pc[1:0] is ignored.
- Entry contents: valid, tag, is_cond, ctr[CTR_W-1:0], target[ADDR_W-1:0].
- Lookup is combinational from registered state, with zero-cycle latency.
  - lk_hit = valid[idx] && tag match.
  - lk_taken = lk_hit && (!is_cond || ctr[CTR_W-1]).
  - When lk_hit=0: lk_taken=0 and lk_target=0.
- Update is applied at the rising edge when upd_valid=1.
  - Hit, unconditional entry: rewrite the entry with upd data. ctr is unchanged for unconditional entries.
  - Hit, conditional entry: ctr saturating +1 if upd_taken, −1 otherwise. Target is overwritten only if upd_taken. is_cond is overwritten.
  - Miss and upd_taken=1: allocate or replace entry idx. Set valid=1, tag, is_cond, target. ctr = weakly-taken (MSB=1, rest 0; e.g. 2'b10).
  - Miss and upd_taken=0: no state change.
  - Entries are never invalidated except by reset.
- Counter saturation:
  - Never wraps.
  - Incrementing all-ones stays all-ones.
  - Decrementing zero stays zero.
- occupancy is a registered count of valid bits.
  - +1 on allocation into an invalid slot.
  - Unchanged on replacement or hit.
  - Reset value 0.
  - Maximum value ENTRIES.
- Same-cycle lookup and update to the same idx: the lookup returns the pre-update contents (no bypass, unless the optional feature is enabled).
- Reset (rst=1 at an edge):
  - All valid bits become 0 and occupancy becomes 0.
  - ctr, tag and target are don't-care.
  - An update presented in the reset cycle is discarded.
  - Outputs: lk_hit=0, lk_taken=0, lk_target=0 from the cycle after reset.
- X-safety: upd_* fields are ignored when upd_valid=0.

Optional Feature:
- BPRED_BYPASS_EN defined: when upd_valid=1 and the update's idx equals the lookup idx in the same cycle, lookup outputs reflect the post-update entry (write-through forwarding).
- BPRED_BYPASS_EN undefined: lookup outputs reflect the pre-update entry.

Decomposition:
- Package bpred_pkg holds:
  - localparam function clog2 for IDX_W.
  - Counter constants CTR_SNT (all 0), CTR_WT (MSB only), CTR_ST (all 1).
  - Functions sat_inc / sat_dec parametrised by CTR_W.
  - Typedef btb_entry_t (valid, tag, is_cond, ctr, target).
- Sub-module bpred_sat_ctr: one CTR_W-bit saturating next-state function with inputs cur, taken, en and output nxt. Instantiate it once in the update path.

Test Plan:
- Reset with rst=1 for 3 cycles, then lk_pc=0x40 → lk_hit=0, lk_taken=0, lk_target=0, occupancy=0.
- Update pc=0x40, cond=1, taken=1, target=0x100; next cycle look up 0x40 → hit=1, taken=1 (ctr=10), target=0x100, occupancy=1.
- Same entry: taken=0 twice → taken=0 after the first (ctr=01) and after the second (ctr=00); a further taken=0 keeps ctr=00; then taken=1 ×3 saturates at 11, and one taken=0 still predicts taken.
- Aliasing: pc=0x40 allocated, then update pc=0x440 (same idx, different tag), uncond, taken, target=0x800 → lookup 0x40 misses; lookup 0x440 gives hit=1, taken=1, target=0x800; occupancy stays 1.
- Miss with taken=0 at pc=0x80 → no allocation, occupancy unchanged.
- Same-cycle update and lookup of 0x40 (fresh, taken, target 0x200):
  - Without BPRED_BYPASS_EN → hit=0 that cycle and hit=1 the next.
  - With BPRED_BYPASS_EN → hit=1, target=0x200 in the same cycle.
  - Fill all 16 indices, then assert rst mid-stream together with upd_valid → occupancy=0 and all lookups miss.
